// File: rtl/mux4x1_checker.sv
`default_nettype none
// ============================================================================
// Module      : mux4x1_checker
// Description : Scoreboard for a 4:1 mux. Predicts mux_out through a LAT-deep
//               pipeline, counts matches/mismatches, records the first failure.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4x1_checker #(
    parameter int WIDTH = 1,
    parameter int LAT   = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] mux_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [1:0]       first_err_sel,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got
);

    localparam int                DW           = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DW-1:0]     c_DRAIN_LAST = DW'((LAT > 0) ? (LAT - 1) : 0);
    localparam logic [CNT_W-1:0]  c_CNT_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DW-1:0]      r_drain_cnt;
    logic               w_drain_last;
    logic               w_clear;
    logic               w_push;
    logic [WIDTH-1:0]   w_exp;
    logic               w_cmp_valid;
    logic [WIDTH-1:0]   w_cmp_exp;
    logic [1:0]         w_cmp_sel;

    logic               r_err;
    logic [CNT_W-1:0]   r_match;
    logic [CNT_W-1:0]   r_mis;
    logic [1:0]         r_fsel;
    logic [WIDTH-1:0]   r_fexp;
    logic [WIDTH-1:0]   r_fgot;

    assign w_clear      = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_push       = (r_state == S_RUN) && valid_in;
    assign w_drain_last = (r_drain_cnt == c_DRAIN_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)        w_state_nxt = S_RUN;
            S_RUN:   if (stop)         w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_last) w_state_nxt = S_DONE;
            S_DONE:  if (start)        w_state_nxt = S_RUN;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counts DRAIN cycles; zero on DRAIN entry so LAT=0 leaves after one clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain_cnt <= '0;
        end else if (r_state != S_DRAIN) begin
            r_drain_cnt <= '0;
        end else begin
            r_drain_cnt <= r_drain_cnt + DW'(1);
        end
    end

    always_comb begin
        w_exp = in0;
        case (sel)
            2'd0:    w_exp = in0;
            2'd1:    w_exp = in1;
            2'd2:    w_exp = in2;
            default: w_exp = in3;
        endcase
    end

    generate
        if (LAT == 0) begin : g_lat0
            assign w_cmp_valid = w_push;
            assign w_cmp_exp   = w_exp;
            assign w_cmp_sel   = sel;
        end else begin : g_pipe
            logic             r_pipe_vld [LAT];
            logic [WIDTH-1:0] r_pipe_exp [LAT];
            logic [1:0]       r_pipe_sel [LAT];

            // Free-running shift so the tail lines up with the DUT's fixed latency
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) begin
                        r_pipe_vld[i] <= 1'b0;
                        r_pipe_exp[i] <= '0;
                        r_pipe_sel[i] <= '0;
                    end
                end else begin
                    r_pipe_vld[0] <= w_push;
                    r_pipe_exp[0] <= w_exp;
                    r_pipe_sel[0] <= sel;
                    for (int i = 1; i < LAT; i++) begin
                        r_pipe_vld[i] <= r_pipe_vld[i-1];
                        r_pipe_exp[i] <= r_pipe_exp[i-1];
                        r_pipe_sel[i] <= r_pipe_sel[i-1];
                    end
                    if (w_clear) begin
                        for (int i = 0; i < LAT; i++) begin
                            r_pipe_vld[i] <= 1'b0;
                        end
                    end
                end
            end

            assign w_cmp_valid = r_pipe_vld[LAT-1];
            assign w_cmp_exp   = r_pipe_exp[LAT-1];
            assign w_cmp_sel   = r_pipe_sel[LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err   <= 1'b0;
            r_match <= '0;
            r_mis   <= '0;
            r_fsel  <= '0;
            r_fexp  <= '0;
            r_fgot  <= '0;
        end else if (w_clear) begin
            r_err   <= 1'b0;
            r_match <= '0;
            r_mis   <= '0;
            r_fsel  <= '0;
            r_fexp  <= '0;
            r_fgot  <= '0;
        end else if (w_cmp_valid) begin
            if (mux_out == w_cmp_exp) begin
                if (r_match != c_CNT_MAX) begin
                    r_match <= r_match + CNT_W'(1);
                end
            end else begin
                if (r_mis != c_CNT_MAX) begin
                    r_mis <= r_mis + CNT_W'(1);
                end
                r_err <= 1'b1;
                if (!r_err) begin
                    r_fsel <= w_cmp_sel;
                    r_fexp <= w_cmp_exp;
                    r_fgot <= mux_out;
                end
            end
        end
    end

    assign busy          = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done          = (r_state == S_DONE);
    assign pass          = done && (r_mis == '0) && (r_match != '0);
    assign err           = r_err;
    assign match_cnt     = r_match;
    assign mismatch_cnt  = r_mis;
    assign first_err_sel = r_fsel;
    assign first_err_exp = r_fexp;
    assign first_err_got = r_fgot;

endmodule
`default_nettype wire

// File: tb/tb_mux4x1_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4x1_checker
// Description : Runs three checker instances (LAT 0/2/1, CNT_W 16/16/3) off
//               shared stimulus against a transaction-level scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4x1_checker;

    logic       clk = 1'b0;
    logic       rst, start, stop, valid_in;
    logic [3:0] in0, in1, in2, in3;
    logic [1:0] sel;
    logic [3:0] mo [3];

    logic        b [3], dn [3], ps [3], er [3];
    logic [15:0] mc [3], xc [3];
    logic [2:0]  mc3, xc3;
    logic [1:0]  fs [3];
    logic [3:0]  fe [3], fg [3];

    int checks   = 0;
    int failures = 0;

    // Scoreboard state, one entry per instance
    int   lat [3] = '{0, 2, 1};
    int   lim [3] = '{65535, 65535, 7};
    int   m_match [3], m_mis [3];
    bit   m_err [3];
    logic [1:0] m_fsel [3];
    logic [3:0] m_fexp [3], m_fgot [3];
    bit   m_run;
    logic [3:0] hv [5];
    logic [3:0] hf [3][5];

    always #5 clk = ~clk;

    mux4x1_checker #(.WIDTH(4), .LAT(0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .valid_in(valid_in),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .sel(sel), .mux_out(mo[0]),
        .busy(b[0]), .done(dn[0]), .pass(ps[0]), .err(er[0]),
        .match_cnt(mc[0]), .mismatch_cnt(xc[0]),
        .first_err_sel(fs[0]), .first_err_exp(fe[0]), .first_err_got(fg[0]));

    mux4x1_checker #(.WIDTH(4), .LAT(2), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .valid_in(valid_in),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .sel(sel), .mux_out(mo[1]),
        .busy(b[1]), .done(dn[1]), .pass(ps[1]), .err(er[1]),
        .match_cnt(mc[1]), .mismatch_cnt(xc[1]),
        .first_err_sel(fs[1]), .first_err_exp(fe[1]), .first_err_got(fg[1]));

    mux4x1_checker #(.WIDTH(4), .LAT(1), .CNT_W(3)) u2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .valid_in(valid_in),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .sel(sel), .mux_out(mo[2]),
        .busy(b[2]), .done(dn[2]), .pass(ps[2]), .err(er[2]),
        .match_cnt(mc3), .mismatch_cnt(xc3),
        .first_err_sel(fs[2]), .first_err_exp(fe[2]), .first_err_got(fg[2]));

    assign mc[2] = {13'd0, mc3};
    assign xc[2] = {13'd0, xc3};

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            m_match[d] = 0; m_mis[d] = 0; m_err[d] = 1'b0;
            m_fsel[d] = '0; m_fexp[d] = '0; m_fgot[d] = '0;
        end
    endtask

    // One clock of stimulus; the emulated mux answers LAT cycles later, XORed
    // with the per-instance corruption mask chosen for that transaction.
    task automatic step(input bit v, input logic [3:0] a, input logic [3:0] bb,
                        input logic [3:0] c, input logic [3:0] dd, input logic [1:0] s,
                        input bit st, input bit sp,
                        input logic [3:0] f0, input logic [3:0] f1, input logic [3:0] f2);
        logic [3:0] inw [4];
        logic [3:0] fl [3];
        logic [3:0] corr;
        inw = '{a, bb, c, dd};
        fl  = '{f0, f1, f2};
        corr = inw[s];
        for (int k = 4; k > 0; k--) begin
            hv[k] = hv[k-1];
            for (int d = 0; d < 3; d++) hf[d][k] = hf[d][k-1];
        end
        hv[0] = corr;
        for (int d = 0; d < 3; d++) hf[d][0] = (v && m_run) ? fl[d] : 4'd0;
        for (int d = 0; d < 3; d++) mo[d] = hv[lat[d]] ^ hf[d][lat[d]];
        in0 = a; in1 = bb; in2 = c; in3 = dd; sel = s;
        valid_in = v; start = st; stop = sp;
        if (m_run && v) begin
            for (int d = 0; d < 3; d++) begin
                if (fl[d] == 4'd0) begin
                    if (m_match[d] < lim[d]) m_match[d]++;
                end else begin
                    if (m_mis[d] < lim[d]) m_mis[d]++;
                    if (!m_err[d]) begin
                        m_fsel[d] = s; m_fexp[d] = corr; m_fgot[d] = corr ^ fl[d];
                    end
                    m_err[d] = 1'b1;
                end
            end
        end
        if (st && !m_run) begin
            model_clear();
            m_run = 1'b1;
        end else if (sp && m_run) begin
            m_run = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit v, input bit st, input bit sp);
        step(v, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
             st, sp, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic good_txn(input logic [1:0] s);
        step(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), s,
             1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(dn[0] && dn[1] && dn[2]) && n < 20) begin
            idle(1'b0, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (!(dn[0] && dn[1] && dn[2])) begin
            failures++;
            $display("FAIL wait_done timeout got=%b%b%b exp=111", dn[0], dn[1], dn[2]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({b[d], dn[d], ps[d], er[d], mc[d], xc[d], fs[d], fe[d], fg[d]} !== '0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d got=%b%b%b%b mc=%0d xc=%0d exp=all zero",
                         d, b[d], dn[d], ps[d], er[d], mc[d], xc[d]);
            end
        end
        rst = 1'b0;
        m_run = 1'b0;
        model_clear();
        idle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_lat0_basic();
        int expm [3] = '{8, 8, 7};
        idle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) good_txn(2'(i));
        idle(1'b0, 1'b0, 1'b1);
        wait_done();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ps[d] !== 1'b1 || xc[d] !== 16'd0 || mc[d] !== 16'(expm[d])) begin
                failures++;
                $display("FAIL basic_run dut%0d got pass=%b mc=%0d xc=%0d exp pass=1 mc=%0d xc=0",
                         d, ps[d], mc[d], xc[d], expm[d]);
            end
        end
    endtask

    task automatic test_lat2_err();
        idle(1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd0, 4'd1, 4'd0, 4'd1, 2'd1, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0);
        idle(1'b0, 1'b0, 1'b1);
        wait_done();
        checks++;
        if (er[1] !== 1'b1 || fs[1] !== 2'd1 || fe[1] !== 4'd1 || fg[1] !== 4'd0 ||
            ps[1] !== 1'b0 || xc[1] !== 16'd1) begin
            failures++;
            $display("FAIL lat2_first_err got err=%b sel=%0d exp=%0d got=%0d pass=%b xc=%0d required 1/1/1/0/0/1",
                     er[1], fs[1], fe[1], fg[1], ps[1], xc[1]);
        end
        checks++;
        if (ps[0] !== 1'b1 || mc[0] !== 16'd1 || er[0] !== 1'b0) begin
            failures++;
            $display("FAIL lat2_neighbour got pass=%b mc=%0d err=%b exp 1/1/0", ps[0], mc[0], er[0]);
        end
    endtask

    task automatic test_drain();
        int nb;
        idle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) good_txn(2'($urandom));
        idle(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            for (int d = 0; d < 3; d++) begin
                nb = (lat[d] > 0) ? lat[d] : 1;
                checks++;
                if (b[d] !== (c < nb) || dn[d] !== (c >= nb)) begin
                    failures++;
                    $display("FAIL drain_busy dut%0d cyc%0d got busy=%b done=%b exp busy=%b",
                             d, c, b[d], dn[d], (c < nb));
                end
            end
            idle(1'b1, 1'b0, 1'b0);
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (mc[d] !== 16'd3 || ps[d] !== 1'b1) begin
                failures++;
                $display("FAIL drain_count dut%0d got mc=%0d pass=%b exp mc=3 pass=1", d, mc[d], ps[d]);
            end
        end
    endtask

    task automatic test_saturate();
        idle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) good_txn(2'($urandom));
        idle(1'b0, 1'b0, 1'b1);
        wait_done();
        checks++;
        if (mc[2] !== 16'd7 || ps[2] !== 1'b1 || mc[0] !== 16'd10) begin
            failures++;
            $display("FAIL saturate got mc3=%0d pass=%b mc16=%0d exp 7/1/10", mc[2], ps[2], mc[0]);
        end
    endtask

    task automatic test_random();
        int n;
        logic [3:0] f [3];
        for (int r = 0; r < 5; r++) begin
            idle(1'b0, 1'b1, 1'b0);
            n = $urandom_range(5, 40);
            for (int i = 0; i < n; i++) begin
                for (int d = 0; d < 3; d++)
                    f[d] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                step(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 4'($urandom),
                     4'($urandom), 2'($urandom), ($urandom_range(0, 9) == 0), 1'b0,
                     f[0], f[1], f[2]);
            end
            idle(1'($urandom), 1'b0, 1'b1);
            wait_done();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (mc[d] !== 16'(m_match[d]) || xc[d] !== 16'(m_mis[d]) || er[d] !== m_err[d] ||
                    fs[d] !== m_fsel[d] || fe[d] !== m_fexp[d] || fg[d] !== m_fgot[d] ||
                    ps[d] !== (m_mis[d] == 0 && m_match[d] != 0)) begin
                    failures++;
                    $display("FAIL random_run%0d dut%0d got mc=%0d xc=%0d err=%b fs=%0d fe=%0d fg=%0d exp mc=%0d xc=%0d err=%b fs=%0d fe=%0d fg=%0d",
                             r, d, mc[d], xc[d], er[d], fs[d], fe[d], fg[d],
                             m_match[d], m_mis[d], m_err[d], m_fsel[d], m_fexp[d], m_fgot[d]);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        idle(1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 2'd0, 1'b0, 1'b0, 4'd5, 4'd5, 4'd5);
        step(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 2'd3, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({b[d], dn[d], ps[d], er[d], mc[d], xc[d], fs[d], fe[d], fg[d]} !== '0) begin
                failures++;
                $display("FAIL midrun_async_reset dut%0d got busy=%b err=%b mc=%0d xc=%0d exp all zero",
                         d, b[d], er[d], mc[d], xc[d]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_run = 1'b0;
        model_clear();
        for (int i = 0; i < 5; i++) idle(1'b1, 1'b0, (i == 2));
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (b[d] !== 1'b0 || dn[d] !== 1'b0 || er[d] !== 1'b0 || mc[d] !== 16'd0 || xc[d] !== 16'd0) begin
                failures++;
                $display("FAIL midrun_after_release dut%0d got busy=%b done=%b err=%b mc=%0d xc=%0d exp 0",
                         d, b[d], dn[d], er[d], mc[d], xc[d]);
            end
        end
    endtask

    task automatic test_start_stop_done();
        idle(1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd9, 4'd8, 4'd7, 4'd6, 2'd2, 1'b0, 1'b0, 4'd3, 4'd3, 4'd3);
        good_txn(2'd1);
        idle(1'b0, 1'b0, 1'b1);
        wait_done();
        idle(1'b0, 1'b1, 1'b1);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (b[d] !== 1'b1 || dn[d] !== 1'b0 || er[d] !== 1'b0 || mc[d] !== 16'd0 ||
                xc[d] !== 16'd0 || fe[d] !== 4'd0 || fg[d] !== 4'd0) begin
                failures++;
                $display("FAIL start_stop_in_done dut%0d got busy=%b done=%b err=%b mc=%0d xc=%0d exp busy=1 rest 0",
                         d, b[d], dn[d], er[d], mc[d], xc[d]);
            end
        end
        idle(1'b0, 1'b0, 1'b1);
        wait_done();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; valid_in = 1'b0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0; sel = '0;
        for (int d = 0; d < 3; d++) begin
            mo[d] = '0;
            for (int k = 0; k < 5; k++) hf[d][k] = '0;
        end
        for (int k = 0; k < 5; k++) hv[k] = '0;
        m_run = 1'b0;
        model_clear();
        @(posedge clk); #1;
        test_reset();
        test_lat0_basic();
        test_lat2_err();
        test_drain();
        test_saturate();
        test_random();
        test_reset_midrun();
        test_start_stop_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
